// File: rtl/pulse_burst_gen_if.sv
// rtl/pulse_burst_gen_if.sv - burst request, latched parameters and pulse-train status
interface pulse_burst_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_pulses;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             out_sig;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, num_pulses, high_len, low_len,
    input  out_sig, busy, done
  );

  modport slave (
    input  start, abort, num_pulses, high_len, low_len,
    output out_sig, busy, done
  );
endinterface

// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - N-pulse burst generator with programmable high/low widths
module pulse_burst_gen #(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_burst_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] lat_h;
  logic [CNT_W-1:0] lat_l;
  logic [CNT_W-1:0] start_h;
  logic [CNT_W-1:0] start_l;

  // Zero widths behave as one cycle so every loaded phase count is at least 1.
  assign start_h = (bus.high_len == '0) ? ONE : bus.high_len;
  assign start_l = (bus.low_len  == '0) ? ONE : bus.low_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      pulse_cnt   <= '0;
      lat_h       <= '0;
      lat_l       <= '0;
      bus.out_sig <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lat_h     <= start_h;
            lat_l     <= start_l;
            pulse_cnt <= bus.num_pulses;
            if (bus.num_pulses == '0) begin
              bus.done <= 1'b1;
            end else begin
              state       <= S_HIGH;
              phase_cnt   <= start_h;
              bus.out_sig <= 1'b1;
              bus.busy    <= 1'b1;
            end
          end
        end

        S_HIGH: begin
          if (bus.abort) begin
            state       <= S_IDLE;
            phase_cnt   <= '0;
            pulse_cnt   <= '0;
            bus.out_sig <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (phase_cnt == ONE) begin
            state       <= S_LOW;
            phase_cnt   <= lat_l;
            bus.out_sig <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end

        S_LOW: begin
          if (bus.abort) begin
            state       <= S_IDLE;
            phase_cnt   <= '0;
            pulse_cnt   <= '0;
            bus.out_sig <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (phase_cnt == ONE) begin
            // The last pulse also gets its full low phase before done.
            if (pulse_cnt > ONE) begin
              state       <= S_HIGH;
              phase_cnt   <= lat_h;
              pulse_cnt   <= pulse_cnt - ONE;
              bus.out_sig <= 1'b1;
            end else begin
              state     <= S_IDLE;
              phase_cnt <= '0;
              pulse_cnt <= '0;
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt - ONE;
          end
        end

        default: begin
          state       <= S_IDLE;
          bus.out_sig <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Programmable rising-edge burst generator: on a start request it drives `out_sig` with a burst of N clean pulses of configurable high and low widths, then signals completion. It is the stimulus side of the team's sliding-window edge-count checking. It sits in the test and stimulus path and produces a known number of rising edges at a known spacing, so window/threshold detectors can be exercised on-chip.

## Interface
- `CNT_W`, default 4: width of the `num_pulses`, `high_len` and `low_len` inputs and of the internal counters. Maximum value of each is 2^CNT_W − 1.
- `clk`, input, 1: single clock, all logic on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: burst request. Sampled only when `busy`=0.
- `abort`, input, 1: synchronous cancel. Effective only when `busy`=1.
- `num_pulses`, input, CNT_W: number of pulses N. Latched on an accepted `start`.
- `high_len`, input, CNT_W: high-phase length H in cycles. Latched on an accepted `start`.
- `low_len`, input, CNT_W: low-phase length L in cycles. Latched on an accepted `start`.
- `out_sig`, output, 1: generated pulse train. Registered.
- `busy`, output, 1: high while a burst is in progress. Registered.
- `done`, output, 1: one-cycle pulse at normal burst completion. Registered.

## Operation
- FSM states:
  - IDLE: `out_sig`=0, `busy`=0.
  - HIGH: `out_sig`=1, `busy`=1.
  - LOW: `out_sig`=0, `busy`=1.
- IDLE, `start`=1:
  - Latch N, H, L.
  - H=0 is treated as 1; L=0 is treated as 1.
  - If N=0: stay in IDLE, pulse `done` next cycle, `out_sig` never rises.
  - If N>0: go to HIGH, load the phase counter with H and the pulse counter with N.
- HIGH: decrement the phase counter each cycle. At its last cycle, go to LOW and load L.
- LOW: decrement the phase counter each cycle. At its last cycle:
  - If pulses remain, go to HIGH (reload H, decrement the pulse counter).
  - Otherwise go to IDLE and assert `done` for one cycle.
- Every pulse, including the last, is followed by a full L-cycle low phase. The burst therefore ends with `out_sig` low and the rising edges are clean.
- `start` while `busy`=1 is ignored. Input changes while `busy`=1 have no effect; only the latched copies are used.
- `abort`=1 while `busy`=1:
  - Next cycle: IDLE, `out_sig`=0, `busy`=0, `done` stays 0.
  - `abort` has priority over every other transition.
- `abort` while idle: no effect. `start` and `abort` together in IDLE: `start` is accepted.
- `done` and a new `start`: a `start` in the same cycle that `done` is high is accepted, since `busy`=0 in that cycle.
- Counters are CNT_W bits wide, with no wrap and no overflow paths. Loaded values are always ≥1.

## Timing
- Reset values: `out_sig`=0, `busy`=0, `done`=0, state IDLE, counters 0. Reset applies immediately, including mid-burst; no `done` is generated.
- Cycle numbering: `start` accepted at the end of cycle 0.
- Burst timing:
  - `out_sig`=1 in cycles k(H+L)+1 … k(H+L)+H, for k = 0…N−1.
  - Low otherwise.
  - Rising-edge spacing is exactly H+L cycles.
  - K consecutive edges span (K−1)(H+L)+1 cycles.
- `busy`=1 in cycles 1 … N(H+L). `done`=1 in cycle N(H+L)+1 only, with `busy`=0.
- Zero-length handling: with N=0, `done`=1 in cycle 1 and `busy` is never asserted. With H=0 or L=0, timing is as for a value of 1.
- Abort timing: `abort` seen at the end of cycle a → `out_sig`=0 and `busy`=0 from cycle a+1.
- Start-to-first-edge latency is 1 cycle.

## Test plan
- Reset then N=3, H=2, L=3, `start` in cycle 0 → `out_sig` high in cycles 1-2, 6-7 and 11-12; `busy` in cycles 1-15; `done` only in cycle 16.
- N=0 → no `out_sig` activity, `busy` stays 0, `done`=1 in cycle 1. H=0 and L=0 with N=2 → `out_sig` high in cycles 1 and 3, `done` in cycle 5.
- N=4, H=1, L=1; `start` re-pulsed and inputs changed mid-burst → unchanged waveform with 4 edges 2 cycles apart; a `start` in the `done` cycle launches a new burst whose first high is the next cycle.
- N=5, H=3, L=2, `abort` at cycle 7 → `out_sig`=0 and `busy`=0 from cycle 8, `done` never asserted. Async `rst_n` low at cycle 4 of a burst → all outputs 0 immediately, IDLE after release.
- CNT_W=4, N=15, H=15, L=15 → 15 pulses each exactly 15 cycles high, edges 30 cycles apart, `done` at cycle 451, no counter wrap.
